// File: rtl/mem_if_pkg.sv
// Shared widths and arbiter state encoding for the burst-read memory path.
package mem_if_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick
    import mem_if_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // One extra bit on the sum lets the wrap work for non power-of-two N_REQ.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one burst-read memory port between N_REQ requesters, round-robin per burst,
// steering beats to the owner only and flagging burst-length protocol errors.
module mem_read_arbiter
    import mem_if_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        rreq_from_req,
    input  logic [N_REQ*ADDR_W-1:0] raddr_from_req,
    input  logic [N_REQ*LEN_W-1:0]  burst_len_from_req,
    output logic [DATA_W-1:0]       rdata_to_req,
    output logic [N_REQ-1:0]        rvalid_to_req,
    output logic [N_REQ-1:0]        rlast_to_req,
    output logic                    rreq_to_mem,
    output logic [ADDR_W-1:0]       raddr_to_mem,
    output logic [LEN_W-1:0]        burst_len_to_mem,
    input  logic [DATA_W-1:0]       rdata_from_mem,
    input  logic                    rvalid_from_mem,
    input  logic                    rlast_from_mem,
    output logic                    err_to_top
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] pick_grant;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [ADDR_W-1:0] pick_addr;
    logic [LEN_W-1:0] pick_len;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (rreq_from_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_addr = pick_addr | raddr_from_req[i*ADDR_W +: ADDR_W];
                pick_len  = pick_len  | burst_len_from_req[i*LEN_W +: LEN_W];
            end
        end
    end

    // Errors only raise the sticky flag; they never redirect the FSM.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        rreq_to_mem   = 1'b0;
        rvalid_to_req = '0;
        rlast_to_req  = '0;
        case (state_q)
            IDLE: begin
                if (rvalid_from_mem) begin
                    err_d = 1'b1;
                end
                if (pick_any) begin
                    owner_d = pick_idx;
                    addr_d  = pick_addr;
                    len_d   = pick_len;
                    cnt_d   = '0;
                    ptr_d   = (pick_idx == PTR_W'(N_REQ-1)) ? '0 : pick_idx + PTR_W'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rreq_to_mem = 1'b1;
                if (rvalid_from_mem) begin
                    rvalid_to_req[owner_q] = 1'b1;
                    rlast_to_req[owner_q]  = rlast_from_mem;
                    if (rlast_from_mem && (cnt_q != len_q)) begin
                        err_d = 1'b1;
                    end
                    if (!rlast_from_mem && (cnt_q == len_q)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                    if (rlast_from_mem) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (rvalid_from_mem) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign rdata_to_req     = rdata_from_mem;
    assign raddr_to_mem     = addr_q;
    assign burst_len_to_mem = len_q;
    assign err_to_top       = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed scenarios plus randomized requester/memory traffic against a burst-level reference model.
module tb_mem_read_arbiter;
    import mem_if_pkg::*;

    localparam int N       = 2;
    localparam int CNT_MAX = (1 << LEN_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        rreq_from_req = '0;
    logic [N*ADDR_W-1:0] raddr_from_req = '0;
    logic [N*LEN_W-1:0]  burst_len_from_req = '0;
    logic [DATA_W-1:0]   rdata_to_req;
    logic [N-1:0]        rvalid_to_req;
    logic [N-1:0]        rlast_to_req;
    logic                rreq_to_mem;
    logic [ADDR_W-1:0]   raddr_to_mem;
    logic [LEN_W-1:0]    burst_len_to_mem;
    logic [DATA_W-1:0]   rdata_from_mem = '0;
    logic                rvalid_from_mem = 1'b0;
    logic                rlast_from_mem = 1'b0;
    logic                err_to_top;

    always #5 clk = ~clk;

    mem_read_arbiter #(.N_REQ(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .rreq_from_req      (rreq_from_req),
        .raddr_from_req     (raddr_from_req),
        .burst_len_from_req (burst_len_from_req),
        .rdata_to_req       (rdata_to_req),
        .rvalid_to_req      (rvalid_to_req),
        .rlast_to_req       (rlast_to_req),
        .rreq_to_mem        (rreq_to_mem),
        .raddr_to_mem       (raddr_to_mem),
        .burst_len_to_mem   (burst_len_to_mem),
        .rdata_from_mem     (rdata_from_mem),
        .rvalid_from_mem    (rvalid_from_mem),
        .rlast_from_mem     (rlast_from_mem),
        .err_to_top         (err_to_top)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: phase 0 = waiting, 1 = burst in flight, 2 = turnaround cycle.
    int                m_phase;
    int                m_owner;
    int                m_ptr;
    int                m_len;
    int                m_beats;
    logic [ADDR_W-1:0] m_addr;
    logic              m_err;
    int                m_last_owner;
    int                beats_seen [N];

    logic [N*ADDR_W-1:0] pend_addr = '0;
    logic [N*LEN_W-1:0]  pend_len = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void modelReset();
        m_phase      = 0;
        m_owner      = 0;
        m_ptr        = 0;
        m_len        = 0;
        m_beats      = 0;
        m_addr       = '0;
        m_err        = 1'b0;
        m_last_owner = -1;
    endfunction

    function automatic void clearBeats();
        for (int i = 0; i < N; i++) beats_seen[i] = 0;
    endfunction

    task automatic setReq(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        pend_addr[i*ADDR_W +: ADDR_W] = a;
        pend_len[i*LEN_W +: LEN_W]    = l;
    endtask

    // Compare this cycle's outputs with the model, then step the model over the coming edge.
    task automatic checkCycle();
        logic [N-1:0] exp_valid;
        logic [N-1:0] exp_last;
        int           winner;
        exp_valid = '0;
        exp_last  = '0;
        if (m_phase == 1 && rvalid_from_mem) begin
            exp_valid[m_owner] = 1'b1;
            exp_last[m_owner]  = rlast_from_mem;
        end
        checkOutput("rreq_to_mem", 32'(rreq_to_mem), 32'(m_phase == 1));
        checkOutput("raddr_to_mem", 32'(raddr_to_mem), 32'(m_addr));
        checkOutput("burst_len_to_mem", 32'(burst_len_to_mem), m_len);
        checkOutput("rvalid_to_req", 32'(rvalid_to_req), 32'(exp_valid));
        checkOutput("rlast_to_req", 32'(rlast_to_req), 32'(exp_last));
        checkOutput("rdata_to_req", 32'(rdata_to_req), 32'(rdata_from_mem));
        checkOutput("err_to_top", 32'(err_to_top), 32'(m_err));
        for (int i = 0; i < N; i++) begin
            if (rvalid_to_req[i]) beats_seen[i]++;
        end
        m_last_owner = -1;
        case (m_phase)
            0: begin
                if (rvalid_from_mem) m_err = 1'b1;
                winner = -1;
                for (int k = 0; k < N; k++) begin
                    if (winner < 0 && rreq_from_req[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
                end
                if (winner >= 0) begin
                    m_owner = winner;
                    m_addr  = raddr_from_req[winner*ADDR_W +: ADDR_W];
                    m_len   = int'(burst_len_from_req[winner*LEN_W +: LEN_W]);
                    m_beats = 0;
                    m_ptr   = (winner + 1) % N;
                    m_phase = 1;
                end
            end
            1: begin
                if (rvalid_from_mem) begin
                    if (rlast_from_mem && m_beats != m_len) m_err = 1'b1;
                    if (!rlast_from_mem && m_beats == m_len) m_err = 1'b1;
                    if (m_beats < CNT_MAX) m_beats++;
                    if (rlast_from_mem) begin
                        m_phase      = 2;
                        m_last_owner = m_owner;
                    end
                end
            end
            default: begin
                if (rvalid_from_mem) m_err = 1'b1;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic valid, input logic last,
                                 input logic [DATA_W-1:0] data);
        @(negedge clk);
        rreq_from_req      = req;
        raddr_from_req     = pend_addr;
        burst_len_from_req = pend_len;
        rvalid_from_mem    = valid;
        rlast_from_mem     = last;
        rdata_from_mem     = data;
        #1;
        checkCycle();
    endtask

    task automatic runBurst(input logic [N-1:0] req, input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            applyStimulus(req, 1'b1, i == last_at, DATA_W'($urandom));
        end
    endtask

    // Reset lands mid-cycle with a beat on the bus; outputs must clear without waiting for a clock.
    task automatic doReset();
        @(negedge clk);
        rvalid_from_mem = 1'b1;
        rlast_from_mem  = 1'b0;
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_rreq", 32'(rreq_to_mem), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid_to_req), 32'd0);
        checkOutput("rst_rlast", 32'(rlast_to_req), 32'd0);
        checkOutput("rst_raddr", 32'(raddr_to_mem), 32'd0);
        checkOutput("rst_len", 32'(burst_len_to_mem), 32'd0);
        checkOutput("rst_err", 32'(err_to_top), 32'd0);
        rreq_from_req   = '0;
        rvalid_from_mem = 1'b0;
        #1 reset = 1'b0;
        modelReset();
    endtask

    task automatic randomPhase(input int cycles);
        logic [N-1:0] want;
        logic [N-1:0] blocked;
        int           cool [N];
        int           mem_beats;
        logic         valid;
        logic         last;
        logic         was_busy;
        want      = '0;
        blocked   = '0;
        mem_beats = 0;
        for (int i = 0; i < N; i++) cool[i] = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (cyc % 400 == 399) begin
                doReset();
                want      = '0;
                blocked   = '0;
                mem_beats = 0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (!want[i] && !blocked[i] && cool[i] == 0 && $urandom_range(0, 3) == 0) begin
                    want[i] = 1'b1;
                    setReq(i, ADDR_W'($urandom), LEN_W'($urandom));
                end
                if (cool[i] > 0) cool[i]--;
            end
            if (m_phase == 1 && want[m_owner] && $urandom_range(0, 19) == 0) begin
                want[m_owner]    = 1'b0;
                blocked[m_owner] = 1'b1;
            end
            was_busy = (m_phase == 1);
            if (was_busy) begin
                valid = ($urandom_range(0, 9) < 6);
                last  = (mem_beats >= m_len);
                if ($urandom_range(0, 49) == 0) last = ~last;
            end else begin
                valid = ($urandom_range(0, 49) == 0);
                last  = 1'($urandom);
            end
            applyStimulus(want, valid, last, DATA_W'($urandom));
            if (was_busy && valid) mem_beats++;
            if (m_last_owner >= 0) begin
                want[m_last_owner]    = 1'b0;
                blocked[m_last_owner] = 1'b0;
                cool[m_last_owner]    = 1;
                mem_beats             = 0;
            end
        end
    endtask

    initial begin
        modelReset();
        clearBeats();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_rreq", 32'(rreq_to_mem), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid_to_req), 32'd0);
        checkOutput("reset_raddr", 32'(raddr_to_mem), 32'd0);
        checkOutput("reset_len", 32'(burst_len_to_mem), 32'd0);
        checkOutput("reset_err", 32'(err_to_top), 32'd0);
        reset = 1'b0;

        $display("[TB] quiet bus after reset");
        repeat (20) applyStimulus('0, 1'b0, 1'b0, '0);

        $display("[TB] single requester burst");
        clearBeats();
        setReq(0, 10'h040, 2'd3);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        checkOutput("t2_rreq", 32'(rreq_to_mem), 32'd1);
        checkOutput("t2_raddr", 32'(raddr_to_mem), 32'h040);
        checkOutput("t2_len", 32'(burst_len_to_mem), 32'd3);
        runBurst(2'b01, 4, 3);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t2_rreq_done", 32'(rreq_to_mem), 32'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t2_beats0", beats_seen[0], 4);
        checkOutput("t2_beats1", beats_seen[1], 0);
        checkOutput("t2_err", 32'(err_to_top), 32'd0);

        $display("[TB] rotation between two requesters");
        doReset();
        clearBeats();
        setReq(0, 10'h100, 2'd1);
        setReq(1, 10'h200, 2'd0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        checkOutput("t3_first_addr", 32'(raddr_to_mem), 32'h100);
        runBurst(2'b11, 2, 1);
        applyStimulus(2'b10, 1'b0, 1'b0, '0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        checkOutput("t3_second_addr", 32'(raddr_to_mem), 32'h200);
        runBurst(2'b11, 1, 0);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        checkOutput("t3_third_addr", 32'(raddr_to_mem), 32'h100);
        runBurst(2'b01, 2, 1);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t3_beats0", beats_seen[0], 4);
        checkOutput("t3_beats1", beats_seen[1], 1);
        checkOutput("t3_err", 32'(err_to_top), 32'd0);

        $display("[TB] early last beat");
        doReset();
        setReq(0, 10'h0A0, 2'd3);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        runBurst(2'b01, 2, 1);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t4_err", 32'(err_to_top), 32'd1);
        repeat (5) applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t4_err_sticky", 32'(err_to_top), 32'd1);

        $display("[TB] reset in the middle of a burst");
        doReset();
        clearBeats();
        setReq(0, 10'h080, 2'd3);
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        runBurst(2'b01, 1, 99);
        doReset();
        setReq(1, 10'h300, 2'd1);
        applyStimulus(2'b10, 1'b0, 1'b0, '0);
        applyStimulus(2'b10, 1'b0, 1'b0, '0);
        checkOutput("t5_raddr", 32'(raddr_to_mem), 32'h300);
        runBurst(2'b10, 2, 1);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t5_beats1", beats_seen[1], 2);
        checkOutput("t5_err", 32'(err_to_top), 32'd0);

        $display("[TB] stray beat while idle");
        applyStimulus(2'b00, 1'b1, 1'b0, 8'h5A);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t6_err", 32'(err_to_top), 32'd1);

        $display("[TB] randomized traffic");
        doReset();
        randomPhase(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
